offset_tracker: RTL and testbench
=================================

// Module: offset_tracker
// PURPOSE
//   Per-window DC offset and amplitude estimator for one sampled phase voltage. Feeds
//   the zero-crossing phase measurement stage, which takes offset as its crossing level.
//   Tracks min/max of Vin over WIN accepted samples (one mains cycle), then publishes
//   offset = floor((max+min)/2) and amplitude = floor((max-min)/2). Instantiate one per
//   channel (reference and measured).
// PARAMETERS
//   M     14  sample width, signed two's complement
//   WIN   32  accepted samples per window (samples per mains cycle); WIN >= 2
//   CW     6  window counter width; must hold WIN (2^CW > WIN)
// PORTS
//   clk           in   1  clock, all logic on rising edge
//   rst           in   1  reset, asynchronous, active-low (asserted when 0)
//   sample_en     in   1  Vin holds a new sample this cycle; accept on this edge
//   clear         in   1  synchronous abort of the current window
//   Vin           in   M  signed sample
//   offset        out  M  signed published DC offset
//   amplitude     out  M  unsigned published half peak-to-peak
//   offset_valid  out  1  sticky: at least one window published since reset
//   window_done   out  1  one-cycle pulse when offset/amplitude update
// BEHAVIOUR
// - rst low: offset=0, amplitude=0, offset_valid=0, window_done=0, cnt=0, min=max=0,
//   state=SEED; applies immediately, any partial window is discarded.
// - Registers: min_r, max_r (signed M), cnt (CW bits), state in {SEED, ACC, PUB}.
// - SEED: on sample_en: min_r=max_r=Vin, cnt=1, -> ACC. Otherwise hold.
// - ACC: on sample_en: min_r=min(min_r,Vin), max_r=max(max_r,Vin), cnt=cnt+1;
//   if this is sample number WIN (cnt==WIN-1 before the edge) -> PUB. No sample_en: hold.
// - PUB (exactly one cycle): offset <= (max_r+min_r) computed in M+1 bits signed, then
//   arithmetic shift right 1 (floor toward -inf); amplitude <= (max_r-min_r) in M+1 bits
//   unsigned, then shift right 1 (always fits M bits); offset_valid <= 1; window_done <= 1.
//   If sample_en is high in PUB, that sample seeds the next window (min=max=Vin, cnt=1,
//   -> ACC); else -> SEED. No sample is ever dropped across windows.
// - Latency: outputs and window_done appear on the edge after the edge that accepted
//   sample WIN; window_done low in all other cycles.
// - offset/amplitude hold their last published value between publications and during
//   clear; offset_valid clears only on rst.
// - clear: cnt=0, state -> SEED, min/max don't-care; takes priority over sample_en (that
//   sample is discarded). clear during PUB: publication still happens, next state SEED.
// - No overflow possible: sums/differences computed at M+1 bits.
// TESTING
// 1. rst=0 for 3 cycles mid-window (cnt=17) -> all outputs 0; after release next done
//    only after 32 new samples.
// 2. 32 samples spanning -1000..3000 (M=14) -> one window_done pulse, offset=1000,
//    amplitude=2000, offset_valid=1 and stays 1.
// 3. Samples include -8192 and 8191 -> offset=-1, amplitude=8191 (floor checks).
// 4. Constant Vin=-5 for 32 samples -> offset=-5, amplitude=0.
// 5. sample_en every cycle for 96 samples, ramp 0..95 -> done pulses after samples 32,64,96;
//    window 2 offset=47 (min 32, max 63), proving PUB-cycle sample is kept.
// 6. clear with sample_en at sample 20 -> no done; next done after 32 further samples;
//    prior offset held throughout.

Source files
------------

// File: rtl/offset_tracker.sv
// Per-window DC offset / amplitude estimator: tracks min/max of Vin over WIN accepted
// samples, then publishes floor((max+min)/2) and floor((max-min)/2) for one cycle.
module offset_tracker #(
    parameter int unsigned M   = 14,
    parameter int unsigned WIN = 32,
    parameter int unsigned CW  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sample_en,
    input  logic                clear,
    input  logic signed [M-1:0] Vin,
    output logic signed [M-1:0] offset,
    output logic        [M-1:0] amplitude,
    output logic                offset_valid,
    output logic                window_done
);

    typedef enum logic [1:0] {
        SEED = 2'd0,
        ACC  = 2'd1,
        PUB  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic signed [M-1:0] min_q, min_d;
    logic signed [M-1:0] max_q, max_d;
    logic signed [M-1:0] offset_q, offset_d;
    logic [M-1:0]        amplitude_q, amplitude_d;
    logic                valid_q, valid_d;
    logic                done_q, done_d;

    // One extra bit of headroom so full-scale extremes never wrap.
    logic signed [M:0]   sum_c;
    logic [M:0]          diff_c;

    assign sum_c  = $signed({max_q[M-1], max_q}) + $signed({min_q[M-1], min_q});
    assign diff_c = {max_q[M-1], max_q} - {min_q[M-1], min_q};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        min_d       = min_q;
        max_d       = max_q;
        offset_d    = offset_q;
        amplitude_d = amplitude_q;
        valid_d     = valid_q;
        done_d      = 1'b0;

        case (state_q)
            SEED: begin
                if (sample_en) begin
                    min_d   = Vin;
                    max_d   = Vin;
                    cnt_d   = CW'(1);
                    state_d = ACC;
                end
            end
            ACC: begin
                if (sample_en) begin
                    min_d = (Vin < min_q) ? Vin : min_q;
                    max_d = (Vin > max_q) ? Vin : max_q;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(WIN - 1)) begin
                        state_d = PUB;
                    end
                end
            end
            PUB: begin
                offset_d    = M'(sum_c >>> 1);
                amplitude_d = M'(diff_c >> 1);
                valid_d     = 1'b1;
                done_d      = 1'b1;
                // A sample arriving during publication opens the next window.
                if (sample_en) begin
                    min_d   = Vin;
                    max_d   = Vin;
                    cnt_d   = CW'(1);
                    state_d = ACC;
                end else begin
                    cnt_d   = '0;
                    state_d = SEED;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SEED;
            end
        endcase

        // Abort beats any incoming sample but never cancels a publication in flight.
        if (clear) begin
            cnt_d   = '0;
            min_d   = min_q;
            max_d   = max_q;
            state_d = SEED;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= SEED;
            cnt_q       <= '0;
            min_q       <= '0;
            max_q       <= '0;
            offset_q    <= '0;
            amplitude_q <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            min_q       <= min_d;
            max_q       <= max_d;
            offset_q    <= offset_d;
            amplitude_q <= amplitude_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
        end
    end

    assign offset       = offset_q;
    assign amplitude    = amplitude_q;
    assign offset_valid = valid_q;
    assign window_done  = done_q;

endmodule

// File: tb/tb_offset_tracker.sv
// Directed bench for offset_tracker: hand-computed offset/amplitude per window,
// window_done pulses logged by a monitor and counted.
module tb_offset_tracker;

    localparam int unsigned M   = 14;
    localparam int unsigned WIN = 32;
    localparam int unsigned CW  = 6;

    logic                clk;
    logic                rst;
    logic                sample_en;
    logic                clear;
    logic signed [M-1:0] Vin;
    logic signed [M-1:0] offset;
    logic        [M-1:0] amplitude;
    logic                offset_valid;
    logic                window_done;

    int errors = 0;
    int checks = 0;
    int pub_off[$];
    int pub_amp[$];
    int n0;

    offset_tracker #(.M(M), .WIN(WIN), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_en    (sample_en),
        .clear        (clear),
        .Vin          (Vin),
        .offset       (offset),
        .amplitude    (amplitude),
        .offset_valid (offset_valid),
        .window_done  (window_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Log every cycle window_done is high, so a stretched pulse shows up as an extra entry.
    always @(posedge clk) begin
        if (window_done) begin
            pub_off.push_back(int'(offset));
            pub_amp.push_back(int'(amplitude));
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic en, input logic clr, input int v);
        @(negedge clk);
        sample_en = en;
        clear     = clr;
        Vin       = M'(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
    endtask

    initial begin
        rst       = 1'b0;
        sample_en = 1'b0;
        clear     = 1'b0;
        Vin       = '0;
        repeat (3) @(negedge clk);
        check("rst_offset", int'(offset), 0);
        check("rst_amp", int'(amplitude), 0);
        check("rst_valid", int'(offset_valid), 0);
        check("rst_done", int'(window_done), 0);
        rst = 1'b1;
        idle(2);

        // Window spanning -1000..3000 with gaps between samples
        n0 = pub_off.size();
        for (int i = 0; i < 32; i++) begin
            step(1'b1, 1'b0, (i == 0) ? -1000 : (i == 31) ? 3000 : i * 50);
            step(1'b0, 1'b0, 0);
        end
        idle(3);
        check("w1_pulses", pub_off.size() - n0, 1);
        check("w1_offset", int'(offset), 1000);
        check("w1_amp", int'(amplitude), 2000);
        check("w1_valid", int'(offset_valid), 1);
        idle(4);
        check("w1_valid_sticky", int'(offset_valid), 1);
        check("w1_offset_hold", int'(offset), 1000);

        // Reset mid-window (17 samples in), then a fresh constant -5 window
        for (int i = 0; i < 17; i++) step(1'b1, 1'b0, 7000);
        step(1'b0, 1'b0, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst_offset", int'(offset), 0);
        check("mid_rst_amp", int'(amplitude), 0);
        check("mid_rst_valid", int'(offset_valid), 0);
        check("mid_rst_done", int'(window_done), 0);
        rst = 1'b1;
        n0 = pub_off.size();
        for (int i = 0; i < 31; i++) step(1'b1, 1'b0, -5);
        idle(3);
        check("c5_no_early_done", pub_off.size() - n0, 0);
        check("c5_valid_still_low", int'(offset_valid), 0);
        step(1'b1, 1'b0, -5);
        idle(3);
        check("c5_pulses", pub_off.size() - n0, 1);
        check("c5_offset", int'(offset), -5);
        check("c5_amp", int'(amplitude), 0);
        check("c5_valid", int'(offset_valid), 1);

        // Full-scale extremes: floor(-1/2) = -1, floor(16383/2) = 8191
        n0 = pub_off.size();
        for (int i = 0; i < 32; i++)
            step(1'b1, 1'b0, (i == 3) ? -8192 : (i == 20) ? 8191 : 0);
        idle(3);
        check("fs_pulses", pub_off.size() - n0, 1);
        check("fs_offset", int'(offset), -1);
        check("fs_amp", int'(amplitude), 8191);

        // Clear together with sample 20 discards that sample and the partial window
        n0 = pub_off.size();
        for (int i = 0; i < 19; i++) step(1'b1, 1'b0, -6000);
        step(1'b1, 1'b1, 5000);
        step(1'b0, 1'b0, 0);
        check("clr_offset_hold", int'(offset), -1);
        for (int i = 0; i < 31; i++) step(1'b1, 1'b0, i * 2);
        idle(3);
        check("clr_no_early_done", pub_off.size() - n0, 0);
        check("clr_offset_hold2", int'(offset), -1);
        step(1'b1, 1'b0, 62);
        idle(3);
        check("clr_pulses", pub_off.size() - n0, 1);
        check("clr_offset", int'(offset), 31);
        check("clr_amp", int'(amplitude), 31);

        // Back-to-back ramp 0..95: the sample landing in the PUB cycle must seed window 2
        n0 = pub_off.size();
        for (int i = 0; i < 96; i++) step(1'b1, 1'b0, i);
        idle(4);
        check("ramp_pulses", pub_off.size() - n0, 3);
        if (pub_off.size() - n0 == 3) begin
            check("ramp_w1_offset", pub_off[n0], 15);
            check("ramp_w1_amp", pub_amp[n0], 15);
            check("ramp_w2_offset", pub_off[n0 + 1], 47);
            check("ramp_w2_amp", pub_amp[n0 + 1], 15);
            check("ramp_w3_offset", pub_off[n0 + 2], 79);
            check("ramp_w3_amp", pub_amp[n0 + 2], 15);
        end
        check("ramp_done_low", int'(window_done), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
